// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle: decode/control inputs plus PC and status outputs.
// Latency: none (wires only).
// Backpressure: Stall travels on this bundle; there is no ready signal back.
interface fetch_ctrl_if #(
    parameter int A  = 10,
    parameter int OW = 6
);
    logic          Start;
    logic          Stall;
    logic          Halt;
    logic          BranchEn;
    logic          BranchAbs;
    logic [A-1:0]  Target;
    logic [OW-1:0] Offset;
    logic [A-1:0]  InstAddress;
    logic          Valid;
    logic          Done;
    logic [15:0]   CycleCount;

    // Control / decode side: drives the sequencer, observes PC and status.
    modport master (
        output Start, Stall, Halt, BranchEn, BranchAbs, Target, Offset,
        input  InstAddress, Valid, Done, CycleCount
    );

    // Sequencer side.
    modport slave (
        input  Start, Stall, Halt, BranchEn, BranchAbs, Target, Offset,
        output InstAddress, Valid, Done, CycleCount
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the InstROM: IDLE/RUN/HALTED with branch redirects.
// Latency: PC updates one edge after inputs are sampled; Start -> first Valid is 1 cycle.
// Backpressure: Stall holds the PC and drops Valid; Halt/branches are ignored while stalled.
// Optional macro FETCH_CYCLE_COUNT_EN compiles a saturating RUN-cycle counter onto CycleCount.
module fetch_ctrl #(
    parameter int           A          = 10,
    parameter int           OW         = 6,
    parameter logic [A-1:0] START_ADDR = '0
) (
    input logic        Clk,
    input logic        Reset,
    fetch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t       state;
    logic [A-1:0] pc;
    logic         done_q;

    logic [A-1:0] pc_inc;
    logic [A-1:0] pc_rel;
    logic [A-1:0] branch_pc;

    // Sequential and relative candidates wrap naturally at A bits.
    assign pc_inc    = pc + A'(1);
    assign pc_rel    = pc + A'($signed(bus.Offset));
    assign branch_pc = bus.BranchAbs ? bus.Target : pc_rel;

    // Sequencer FSM: state, PC and the Done flag move together on each edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            pc     <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        pc    <= START_ADDR;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // An instruction held by Stall has not executed, so its
                    // Halt/branch decode must not act yet.
                    if (bus.Stall) begin
                        pc <= pc;
                    end else if (bus.Halt) begin
                        state  <= HALTED;
                        done_q <= 1'b1;
                    end else if (bus.BranchEn) begin
                        pc <= branch_pc;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                HALTED: begin
                    if (bus.Start) begin
                        pc     <= START_ADDR;
                        state  <= RUN;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    pc     <= '0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InstAddress = pc;
    assign bus.Done        = done_q;
    // Valid follows Stall in the same cycle so decode can squash immediately.
    assign bus.Valid       = (state == RUN) && !bus.Stall;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_cnt;
    logic        start_accept;

    assign start_accept = bus.Start && ((state == IDLE) || (state == HALTED));

    // RUN-cycle counter: cleared on an accepted Start, counts stalled cycles too, saturates.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt <= '0;
        end else if (start_accept) begin
            cycle_cnt <= '0;
        end else if ((state == RUN) && (cycle_cnt != 16'hFFFF)) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign bus.CycleCount = cycle_cnt;
`else
    assign bus.CycleCount = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural PC model.
module tb_fetch_ctrl;

    localparam int A  = 10;
    localparam int OW = 6;

    logic clk;
    logic rst_n;

    fetch_ctrl_if #(.A(A), .OW(OW)) bus ();

    fetch_ctrl #(.A(A), .OW(OW), .START_ADDR('0)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model: program counter as a plain integer, plus mode flags.
    int m_pc;
    bit m_run;
    bit m_halted;
    int m_cnt;

`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    function automatic int exp_cnt();
        return CNT_EN ? m_cnt : 0;
    endfunction

    task automatic model_reset();
        m_pc     = 0;
        m_run    = 1'b0;
        m_halted = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic set_in(input bit st, input bit sl, input bit h, input bit be,
                          input bit ba, input int tgt, input int off);
        bus.Start     = st;
        bus.Stall     = sl;
        bus.Halt      = h;
        bus.BranchEn  = be;
        bus.BranchAbs = ba;
        bus.Target    = A'(tgt);
        bus.Offset    = OW'(off);
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic edge_step();
        int off;
        @(posedge clk);
        if (rst_n) begin
            if (m_run) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (bus.Stall) begin
                    // instruction not executed
                end else if (bus.Halt) begin
                    m_run    = 1'b0;
                    m_halted = 1'b1;
                end else if (bus.BranchEn) begin
                    if (bus.BranchAbs) begin
                        m_pc = int'(bus.Target);
                    end else begin
                        off  = int'($signed(bus.Offset));
                        m_pc = (m_pc + off + 1024) % 1024;
                    end
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                end
            end else if (bus.Start) begin
                m_pc     = 0;
                m_run    = 1'b1;
                m_halted = 1'b0;
                m_cnt    = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        total++;
        if (bus.InstAddress !== 10'd0 || bus.Valid !== 1'b0 || bus.Done !== 1'b0 ||
            bus.CycleCount !== 16'd0) begin
            bad++;
            $display("FAIL reset_init got pc=%0d v=%0b d=%0b c=%0d want 0/0/0/0",
                     bus.InstAddress, bus.Valid, bus.Done, bus.CycleCount);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Reach PC=37 in RUN, then pull reset between edges.
        set_in(1, 0, 0, 0, 0, 0, 0); edge_step();
        set_in(0, 0, 0, 1, 1, 37, 0); edge_step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (bus.InstAddress !== 10'd37 || bus.Valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_setup got pc=%0d v=%0b want pc=37 v=1", bus.InstAddress, bus.Valid);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.InstAddress !== 10'd0 || bus.Valid !== 1'b0 || bus.Done !== 1'b0 ||
            bus.CycleCount !== 16'd0) begin
            bad++;
            $display("FAIL reset_midrun got pc=%0d v=%0b d=%0b c=%0d want 0/0/0/0",
                     bus.InstAddress, bus.Valid, bus.Done, bus.CycleCount);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) edge_step();
        total++;
        if (bus.InstAddress !== 10'd0 || bus.Valid !== 1'b0 || bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got pc=%0d v=%0b d=%0b want idle 0/0/0",
                     bus.InstAddress, bus.Valid, bus.Done);
        end
    endtask

    task automatic test_halt_seq();
        int seq [$];
        set_in(1, 0, 0, 0, 0, 0, 0); edge_step();
        for (int i = 0; i < 10 && !m_halted; i++) begin
            seq.push_back(int'(bus.InstAddress));
            set_in(0, 0, (bus.InstAddress == 10'd4), 0, 0, 0, 0);
            edge_step();
        end
        total++;
        if (seq.size() != 5) begin
            bad++;
            $display("FAIL halt_seq_len got %0d want 5", seq.size());
        end
        for (int i = 0; i < seq.size() && i < 5; i++) begin
            total++;
            if (seq[i] != i) begin
                bad++;
                $display("FAIL halt_seq[%0d] got %0d want %0d", i, seq[i], i);
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (bus.Done !== 1'b1 || bus.Valid !== 1'b0 || bus.InstAddress !== 10'd4) begin
            bad++;
            $display("FAIL halt_done got d=%0b v=%0b pc=%0d want 1/0/4",
                     bus.Done, bus.Valid, bus.InstAddress);
        end
        total++;
        if (bus.CycleCount !== 16'(CNT_EN ? 5 : 0)) begin
            bad++;
            $display("FAIL halt_count got %0d want %0d", bus.CycleCount, CNT_EN ? 5 : 0);
        end
        edge_step();
        total++;
        if (bus.Done !== 1'b1 || bus.InstAddress !== 10'd4) begin
            bad++;
            $display("FAIL halt_level got d=%0b pc=%0d want 1/4", bus.Done, bus.InstAddress);
        end
    endtask

    task automatic test_start_restart();
        // Start in HALTED restarts at START_ADDR and clears the counter.
        set_in(1, 0, 0, 0, 0, 0, 0); edge_step();
        total++;
        if (bus.InstAddress !== 10'd0 || bus.Done !== 1'b0 || bus.CycleCount !== 16'd0) begin
            bad++;
            $display("FAIL restart got pc=%0d d=%0b c=%0d want 0/0/0",
                     bus.InstAddress, bus.Done, bus.CycleCount);
        end
        // Start held while running must not reload the PC.
        set_in(1, 0, 0, 0, 0, 0, 0); edge_step();
        edge_step();
        total++;
        if (bus.InstAddress !== 10'd2 || bus.CycleCount !== 16'(exp_cnt())) begin
            bad++;
            $display("FAIL start_in_run got pc=%0d c=%0d want 2/%0d",
                     bus.InstAddress, bus.CycleCount, exp_cnt());
        end
    endtask

    task automatic test_branches();
        set_in(0, 0, 0, 1, 1, 20, 0); edge_step();
        set_in(0, 0, 0, 1, 1, 3, 0);  edge_step();
        total++;
        if (bus.InstAddress !== 10'd3) begin
            bad++;
            $display("FAIL br_abs got %0d want 3", bus.InstAddress);
        end
        set_in(0, 0, 0, 1, 0, 0, -2); edge_step();
        total++;
        if (bus.InstAddress !== 10'd1) begin
            bad++;
            $display("FAIL br_rel_neg got %0d want 1", bus.InstAddress);
        end
        set_in(0, 0, 0, 1, 0, 0, 31); edge_step();
        total++;
        if (bus.InstAddress !== 10'd32) begin
            bad++;
            $display("FAIL br_rel_pos got %0d want 32", bus.InstAddress);
        end
    endtask

    task automatic test_wrap();
        set_in(0, 0, 0, 1, 1, 1023, 0); edge_step();
        set_in(0, 0, 0, 0, 0, 0, 0);    edge_step();
        total++;
        if (bus.InstAddress !== 10'd0) begin
            bad++;
            $display("FAIL wrap_inc got %0d want 0", bus.InstAddress);
        end
        set_in(0, 0, 0, 1, 1, 1020, 0); edge_step();
        set_in(0, 0, 0, 1, 0, 0, 10);   edge_step();
        total++;
        if (bus.InstAddress !== 10'd6) begin
            bad++;
            $display("FAIL wrap_rel got %0d want 6", bus.InstAddress);
        end
    endtask

    task automatic test_stall();
        set_in(0, 0, 0, 1, 1, 8, 0); edge_step();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 1, 1, 1, 100, 0);
            #1;
            total++;
            if (bus.Valid !== 1'b0 || bus.InstAddress !== 10'd8) begin
                bad++;
                $display("FAIL stall[%0d] got v=%0b pc=%0d want 0/8", i, bus.Valid, bus.InstAddress);
            end
            edge_step();
        end
        set_in(0, 0, 1, 1, 1, 100, 0);
        #1;
        total++;
        if (bus.Valid !== 1'b1 || bus.InstAddress !== 10'd8) begin
            bad++;
            $display("FAIL stall_release got v=%0b pc=%0d want 1/8", bus.Valid, bus.InstAddress);
        end
        edge_step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (bus.Done !== 1'b1 || bus.InstAddress !== 10'd8 ||
            bus.CycleCount !== 16'(exp_cnt())) begin
            bad++;
            $display("FAIL stall_halt got d=%0b pc=%0d c=%0d want 1/8/%0d",
                     bus.Done, bus.InstAddress, bus.CycleCount, exp_cnt());
        end
    endtask

    task automatic test_random();
        bit st, sl, h, be, ba;
        int tgt, off;
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 4) == 0);
            sl  = ($urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 29) == 0);
            be  = ($urandom_range(0, 2) == 0);
            ba  = $urandom_range(0, 1);
            tgt = $urandom_range(0, 1023);
            off = $urandom_range(0, 63) - 32;
            set_in(st, sl, h, be, ba, tgt, off);
            #1;
            total++;
            if (bus.InstAddress !== 10'(m_pc) || bus.Valid !== (m_run && !sl) ||
                bus.Done !== m_halted || bus.CycleCount !== 16'(exp_cnt())) begin
                bad++;
                $display("FAIL rand[%0d] got pc=%0d v=%0b d=%0b c=%0d want pc=%0d v=%0b d=%0b c=%0d",
                         i, bus.InstAddress, bus.Valid, bus.Done, bus.CycleCount,
                         m_pc, m_run && !sl, m_halted, exp_cnt());
            end
            total++;
            if (bus.Valid === 1'b1 && bus.Done === 1'b1) begin
                bad++;
                $display("FAIL rand_excl[%0d] got v=1 d=1 want not both", i);
            end
            edge_step();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_halt_seq();
        test_start_restart();
        test_branches();
        test_wrap();
        test_stall();
        test_start_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
